// File: rtl/sprite_fetch.sv
// Line-by-line sprite fetcher: walks one sprite row through an async ROM
// in step with the horizontal scan, one registered colour index per pixel.
module sprite_fetch #(
    parameter int CORDW    = 16,
    parameter int COLRW    = 4,
    parameter int SPR_W    = 16,
    parameter int SPR_H    = 16,
    parameter int FRAMES   = 2,
    parameter int TRANSP   = 0,
    parameter int LINE_END = 639,
    localparam int ROM_DEPTH = FRAMES * SPR_W * SPR_H,
    localparam int ADDRW     = $clog2(ROM_DEPTH),
    localparam int FRW       = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic [CORDW-1:0] sprx,
    input  logic [CORDW-1:0] spry,
    input  logic [FRW-1:0]   frame,
    output logic [ADDRW-1:0] rom_addr,
    input  logic [COLRW-1:0] rom_data,
    output logic [COLRW-1:0] pix,
    output logic             drawing,
    output logic             done
);

    localparam int OXW  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROWW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT_POS,
        SPR_LINE,
        DONE
    } state_t;

    state_t state, state_n;

    logic [CORDW-1:0] sy_r, sprx_r, spry_r;
    logic [FRW-1:0]   frame_r;
    logic [ROWW-1:0]  row;
    logic [OXW-1:0]   ox;
    logic [CORDW-1:0] d;
    logic             in_rng;
    logic             at_pos;
    logic             at_end;
    logic             ox_last;
    logic             latch;
    logic             load_row;
    logic             cap;

    // Signed line offset into the sprite; sign bit set means above the top
    assign d       = sy_r - spry_r;
    assign in_rng  = !d[CORDW-1] && (d < CORDW'(SPR_H));
    assign at_pos  = (sx == sprx_r - CORDW'(1));
    assign at_end  = (sx == CORDW'(LINE_END));
    assign ox_last = (ox == OXW'(SPR_W - 1));

    assign rom_addr = ADDRW'(frame_r) * ADDRW'(SPR_W * SPR_H)
                    + ADDRW'(row) * ADDRW'(SPR_W)
                    + ADDRW'(ox);

    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        latch    = 1'b0;
        load_row = 1'b0;
        cap      = 1'b0;
        if (start) begin
            latch   = 1'b1;
            state_n = CHECK;
        end else begin
            unique case (state)
                IDLE: state_n = IDLE;
                CHECK: begin
                    if (in_rng) begin
                        load_row = 1'b1;
                        state_n  = WAIT_POS;
                    end else begin
                        state_n = DONE;
                    end
                end
                WAIT_POS: begin
                    if (at_pos) begin
                        cap     = 1'b1;
                        state_n = SPR_LINE;
                    end else if (at_end) begin
                        state_n = DONE;
                    end
                end
                SPR_LINE: begin
                    cap = 1'b1;
                    if (ox_last) state_n = DONE;
                end
                DONE: state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sy_r    <= '0;
            sprx_r  <= '0;
            spry_r  <= '0;
            frame_r <= '0;
            row     <= '0;
            ox      <= '0;
            pix     <= '0;
            drawing <= 1'b0;
        end else begin
            if (latch) begin
                sy_r    <= sy;
                sprx_r  <= sprx;
                spry_r  <= spry;
                frame_r <= frame;
            end
            if (load_row) begin
                row <= d[ROWW-1:0];
                ox  <= '0;
            end
            // ROM data for offset ox lands in pix one cycle later
            if (cap) begin
                pix     <= rom_data;
                drawing <= (rom_data != COLRW'(TRANSP));
                if (!ox_last) ox <= ox + OXW'(1);
            end else begin
                pix     <= '0;
                drawing <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_fetch.sv
// Scoreboard bench for sprite_fetch: a line-level model predicts per-cycle
// address, pixel and done events; a monitor checks every cycle.
module tb_sprite_fetch;

    localparam int SPR_W = 16;
    localparam int SPR_H = 16;
    localparam int NWORD = 512;
    localparam int HMIN  = -160;
    localparam int HLEN  = 800;
    localparam int LEND  = 639;

    localparam int EV_ADDR = 0;
    localparam int EV_PIX  = 1;
    localparam int EV_DONE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] sx;
    logic [15:0] sy = '0;
    logic [15:0] sprx = '0;
    logic [15:0] spry = '0;
    logic [0:0]  frame = '0;
    logic [8:0]  rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  pix;
    logic        drawing;
    logic        done;

    logic [3:0] rom [NWORD];
    longint     cyc = 0;
    int         total = 0;
    int         bad = 0;
    bit         mon_en = 1'b0;

    typedef struct {
        longint c;
        int     kind;
        int     val;
    } ev_t;

    ev_t q[$];

    sprite_fetch dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sx       (sx),
        .sy       (sy),
        .sprx     (sprx),
        .spry     (spry),
        .frame    (frame),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .pix      (pix),
        .drawing  (drawing),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sx_of(longint c);
        return HMIN + int'(c % HLEN);
    endfunction

    assign sx       = 16'(sx_of(cyc));
    assign rom_data = rom[rom_addr];

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d sx=%0d got=%0d want=%0d",
                     name, cyc, sx_of(cyc), act, exp);
        end
    endtask

    // Line-level reference: where the row lands on the scan, and what it shows
    task automatic model_line(longint c0, int sy_v, int sprx_v,
                              int spry_v, int fr);
        int  d;
        int  base;
        bit  found;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].c > c0) q.delete(i);
        d = sy_v - spry_v;
        if (d < 0 || d >= SPR_H) begin
            q.push_back('{c0 + 2, EV_DONE, 1});
            return;
        end
        found = 1'b0;
        for (longint c = c0 + 2; c < c0 + 2 + 2 * HLEN && !found; c++) begin
            if (sx_of(c) == sprx_v - 1) begin
                base = fr * SPR_W * SPR_H + d * SPR_W;
                for (int i = 0; i < SPR_W; i++) begin
                    q.push_back('{c + i, EV_ADDR, base + i});
                    q.push_back('{c + 1 + i, EV_PIX, int'(rom[base + i])});
                end
                q.push_back('{c + SPR_W, EV_DONE, 1});
                found = 1'b1;
            end else if (sx_of(c) == LEND) begin
                q.push_back('{c + 1, EV_DONE, 1});
                found = 1'b1;
            end
        end
    endtask

    task automatic issue(int sy_v, int sprx_v, int spry_v, int fr);
        sy    = 16'(sy_v);
        sprx  = 16'(sprx_v);
        spry  = 16'(spry_v);
        frame = 1'(fr);
        start = 1'b1;
        model_line(cyc, sy_v, sprx_v, spry_v, fr);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_sx(int v);
        int n;
        n = 0;
        while (sx_of(cyc) != v && n < 2 * HLEN) begin
            @(negedge clk);
            n++;
        end
        if (sx_of(cyc) != v) check("wait_sx", sx_of(cyc), v);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 3 * HLEN) begin
            @(negedge clk);
            n++;
        end
        check("drain", q.size(), 0);
    endtask

    always @(negedge clk) begin
        bit got_pix;
        bit got_done;
        #1;
        if (mon_en) begin
            got_pix  = 1'b0;
            got_done = 1'b0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].c == cyc) begin
                    case (q[i].kind)
                        EV_ADDR: check("addr", int'(rom_addr), q[i].val);
                        EV_PIX: begin
                            check("pix", int'(pix), q[i].val);
                            check("drawing", int'(drawing),
                                  (q[i].val != 0) ? 1 : 0);
                            got_pix = 1'b1;
                        end
                        default: begin
                            check("done", int'(done), 1);
                            got_done = 1'b1;
                        end
                    endcase
                    q.delete(i);
                end
            end
            if (!got_pix) begin
                check("idle_drawing", int'(drawing), 0);
                check("idle_pix", int'(pix), 0);
            end
            if (!got_done) check("idle_done", int'(done), 0);
        end
    end

    initial begin
        for (int i = 0; i < NWORD; i++) rom[i] = 4'($urandom_range(1, 15));
        rom[256] = 4'd0;

        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            check("reset_addr", int'(rom_addr), 0);
        end

        wait_sx(HMIN);
        issue(20, 100, 16, 0);
        wait_sx(HMIN);
        issue(40, 100, 16, 0);
        wait_sx(HMIN);
        issue(0, 50, 0, 1);
        wait_sx(HMIN);
        issue(5, 700, 0, 0);

        wait_sx(HMIN);
        issue(3, 200, 0, 0);
        wait_sx(205);
        issue(7, 300, 4, 1);

        wait_sx(HMIN);
        issue(15, 1, 0, 0);
        wait_sx(HMIN);
        issue(9, 1, 10, 1);
        wait_sx(HMIN);
        issue(31, LEND, 16, 1);

        wait_sx(HMIN);
        issue(10, 100, 0, 0);
        wait_sx(105);
        rst_n = 1'b0;
        q.delete();
        #1;
        check("arst_drawing", int'(drawing), 0);
        check("arst_pix", int'(pix), 0);
        check("arst_addr", int'(rom_addr), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drain();

        for (int i = 0; i < NWORD; i++)
            rom[i] = ($urandom_range(0, 3) == 0) ? 4'd0
                                                 : 4'($urandom_range(1, 15));
        for (int it = 0; it < 40; it++) begin
            int syv;
            wait_sx(HMIN + int'($urandom_range(0, 120)));
            syv = int'($urandom_range(0, 479));
            issue(syv, int'($urandom_range(1, 700)),
                  syv + 3 - int'($urandom_range(0, 24)),
                  int'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 400)) @(negedge clk);
                syv = int'($urandom_range(0, 479));
                issue(syv, int'($urandom_range(1, 700)),
                      syv + 3 - int'($urandom_range(0, 24)),
                      int'($urandom_range(0, 1)));
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
